lsu_bus_ctrl: RTL and testbench
===============================

LSU_BUS_CTRL -- requirements
Module: lsu_bus_ctrl

Interface
REQ-001 SHALL have parameter N_SLV, default 2, number of slave ports (1..4).
REQ-002 SHALL have parameter SLV_BASE, default {32'h1000_0000, 32'h0000_0000}, per-slave base address; slave i occupies bits [32*i+31:32*i].
REQ-003 SHALL have parameter SLV_MASK, default {32'hFFFF_FFE0, 32'hF000_0000}, per-slave compare mask, same packing as SLV_BASE.
REQ-004 SHALL have parameter TMO_CYC, default 16, slave-ready timeout in cycles (2..255).
REQ-005 SHALL have ports: clk in 1 clock; rst_n in 1 asynchronous active-low reset.
REQ-006 SHALL have ports: lsu_i_valid in 1; lsu_o_ready out 1; agu_i_cmd_read in 1; agu_i_cmd_write in 1; agu_i_cmd_usign in 1; agu_i_cmd_size in 2 (00 B, 01 H, 10 W); agu_i_cmd_addr in 32; agu_i_cmd_wdata in 32.
REQ-007 SHALL have ports: lsu_slv_valid out N_SLV; lsu_slv_wr out 1; lsu_slv_addr out 32; lsu_slv_wdata out 32; lsu_slv_wstrb out 4; slv_lsu_ready in N_SLV; slv_lsu_rdata in 32*N_SLV.
REQ-008 SHALL have ports: lsu_o_wbck_valid out 1; lsu_o_wbck_ready in 1; lsu_o_wbck_wdata out 32; lsu_o_wbck_err out 1; lsu_o_wbck_cause out 2 (00 none, 01 misaligned, 10 unmapped, 11 timeout).

Function
REQ-009 SHALL implement FSM states IDLE, ACCESS, RESP; lsu_o_ready = (state==IDLE).
REQ-010 SHALL accept a command on lsu_i_valid & lsu_o_ready and register read/write/usign/size/addr/wdata in that cycle.
REQ-011 SHALL select slave as lowest index i with (addr & SLV_MASK[i]) == (SLV_BASE[i] & SLV_MASK[i]); overlaps resolved by lowest index.
REQ-012 SHALL flag misaligned when H with addr[0]=1 or W with addr[1:0]!=0; misaligned takes priority over unmapped.
REQ-013 SHALL on accept go IDLE->RESP with error when misaligned or unmapped, asserting no lsu_slv_valid; else IDLE->ACCESS.
REQ-014 SHALL in ACCESS assert only the selected lsu_slv_valid bit, addr = {addr[31:2],2'b00}, wr = registered write, held stable until that slave's ready.
REQ-015 SHALL on selected slv_lsu_ready in ACCESS capture rdata, deassert valid next cycle, go to RESP; single-beat handshake, no read-modify-write.
REQ-016 SHALL generate wstrb: B -> 4'b0001<<addr[1:0], wdata byte replicated x4; H -> 0011 or 1100 by addr[1], halfword replicated x2; W -> 1111; wstrb = 0 for reads.
REQ-017 SHALL extract read data by size/offset, zero-extend when usign else sign-extend; writes return wbck_wdata = 0.
REQ-018 SHALL hold lsu_o_wbck_valid, wdata, err, cause stable in RESP until lsu_o_wbck_ready, then return to IDLE; next command accepted the cycle after.
REQ-019 SHALL give minimum latency: accept at cycle N, zero-wait slave ready at N+1, wbck_valid at N+2; error path wbck_valid at N+1.
REQ-020 SHALL ignore agu_i_* changes outside the accept cycle.

Reset
REQ-021 SHALL on rst_n low force state IDLE, all lsu_slv_valid 0, lsu_o_wbck_valid 0, wbck_err 0, cause 00, wdata 0, wstrb 0, timeout counter 0, asynchronously including mid-ACCESS; lsu_o_ready = 1 out of reset.

Configuration
REQ-022 SHALL with LSU_BUS_TIMEOUT_EN defined count ACCESS cycles from 0 and, if selected ready is not seen by count TMO_CYC-1, drop lsu_slv_valid and enter RESP with err=1, cause=11; ready in that same final cycle wins over timeout.
REQ-023 SHALL without LSU_BUS_TIMEOUT_EN wait in ACCESS indefinitely, contain no counter, never emit cause 11.

Verification
REQ-024 SHALL cover LW 0x0000_0040, slave0 ready at N+1 with 0x8765_4321 -> wbck_valid at N+2, wdata 0x8765_4321, err 0.
REQ-025 SHALL cover LB 0x0000_0043 signed, rdata 0x80FF_FFFF -> wdata 0xFFFF_FF80; LBU same -> 0x0000_0080.
REQ-026 SHALL cover SH 0x1000_0006 wdata 0x0000_ABCD -> lsu_slv_valid=2'b10, wstrb 1100, slv_wdata 0xABCD_ABCD, addr 0x1000_0004.
REQ-027 SHALL cover LW 0x0000_0002 -> no slave valid, wbck at N+1, err 1, cause 01; LW 0x2000_0000 -> cause 10.
REQ-028 SHALL cover LSU_BUS_TIMEOUT_EN, TMO_CYC=4, slave never ready -> valid high exactly 4 cycles, then cause 11; wbck_ready held low 3 cycles -> outputs stable, lsu_o_ready 0.
REQ-029 SHALL cover rst_n pulsed low mid-ACCESS -> slave valid 0 immediately, lsu_o_ready 1 after release, next LW completes normally.

Source files
------------

// File: rtl/lsu_bus_ctrl.sv
// LSU bus controller: decodes one load/store per transaction onto a
// single-beat slave bus and returns aligned, extended writeback data.
//
// Ports
//   clk, rst_n            clock, async active-low reset
//   lsu_i_valid/o_ready   command handshake (ready only in IDLE)
//   agu_i_cmd_*           read/write/usign/size/addr/wdata, sampled on accept
//   lsu_slv_*             one-hot valid, wr, word addr, wdata, wstrb
//   slv_lsu_ready/rdata   per-slave ready and packed read data
//   lsu_o_wbck_*          writeback valid/ready, data, err, cause
//
// Optional: define LSU_BUS_TIMEOUT_EN to abort ACCESS after TMO_CYC
// cycles without slave ready (cause 2'b11).

module lsu_bus_ctrl #(
  parameter int                  N_SLV    = 2,
  parameter logic [32*N_SLV-1:0] SLV_BASE = {32'h1000_0000, 32'h0000_0000},
  parameter logic [32*N_SLV-1:0] SLV_MASK = {32'hFFFF_FFE0, 32'hF000_0000},
  parameter int                  TMO_CYC  = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               lsu_i_valid,
  output logic               lsu_o_ready,
  input  logic               agu_i_cmd_read,
  input  logic               agu_i_cmd_write,
  input  logic               agu_i_cmd_usign,
  input  logic [1:0]         agu_i_cmd_size,
  input  logic [31:0]        agu_i_cmd_addr,
  input  logic [31:0]        agu_i_cmd_wdata,
  output logic [N_SLV-1:0]   lsu_slv_valid,
  output logic               lsu_slv_wr,
  output logic [31:0]        lsu_slv_addr,
  output logic [31:0]        lsu_slv_wdata,
  output logic [3:0]         lsu_slv_wstrb,
  input  logic [N_SLV-1:0]   slv_lsu_ready,
  input  logic [32*N_SLV-1:0] slv_lsu_rdata,
  output logic               lsu_o_wbck_valid,
  input  logic               lsu_o_wbck_ready,
  output logic [31:0]        lsu_o_wbck_wdata,
  output logic               lsu_o_wbck_err,
  output logic [1:0]         lsu_o_wbck_cause
);

  if (N_SLV < 1 || N_SLV > 4) begin : g_chk_nslv
    $error("N_SLV out of range");
  end
  if (TMO_CYC < 2 || TMO_CYC > 255) begin : g_chk_tmo
    $error("TMO_CYC out of range");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [1:0] C_NONE = 2'b00;
  localparam logic [1:0] C_MIS  = 2'b01;
  localparam logic [1:0] C_UNM  = 2'b10;
`ifdef LSU_BUS_TIMEOUT_EN
  localparam logic [1:0] C_TMO  = 2'b11;
`endif

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;

  state_t             r_state, w_state;
  logic               r_read,  w_read;
  logic               r_write, w_write;
  logic               r_usign, w_usign;
  logic [1:0]         r_size,  w_size;
  logic [31:0]        r_addr,  w_addr;
  logic [31:0]        r_wbus,  w_wbus;
  logic [3:0]         r_strb,  w_strb;
  logic [N_SLV-1:0]   r_sel,   w_sel;
  logic [31:0]        r_wbd,   w_wbd;
  logic               r_err,   w_err;
  logic [1:0]         r_cause, w_cause;
`ifdef LSU_BUS_TIMEOUT_EN
  logic [7:0]         r_tmo,   w_tmo;
`endif

  logic [N_SLV-1:0]   w_dec_sel;
  logic               w_hit;
  logic               w_mis;
  logic [3:0]         w_dec_strb;
  logic [31:0]        w_dec_wbus;
  logic               w_rdy;
  logic [31:0]        w_rdata;
  logic [31:0]        w_sh;
  logic [31:0]        w_ext;

  // Address decode; descending scan so the lowest matching index wins.
  always_comb begin
    w_dec_sel = '0;
    w_hit     = 1'b0;
    for (int i = N_SLV - 1; i >= 0; i--) begin
      if ((agu_i_cmd_addr & SLV_MASK[32*i +: 32]) ==
          (SLV_BASE[32*i +: 32] & SLV_MASK[32*i +: 32])) begin
        w_dec_sel    = '0;
        w_dec_sel[i] = 1'b1;
        w_hit        = 1'b1;
      end
    end
  end

  always_comb begin
    w_mis      = 1'b0;
    w_dec_strb = 4'b1111;
    w_dec_wbus = agu_i_cmd_wdata;
    unique case (agu_i_cmd_size)
      SZ_B: begin
        w_dec_strb = 4'b0001 << agu_i_cmd_addr[1:0];
        w_dec_wbus = {4{agu_i_cmd_wdata[7:0]}};
      end
      SZ_H: begin
        w_mis      = agu_i_cmd_addr[0];
        w_dec_strb = agu_i_cmd_addr[1] ? 4'b1100 : 4'b0011;
        w_dec_wbus = {2{agu_i_cmd_wdata[15:0]}};
      end
      default: begin
        w_mis = |agu_i_cmd_addr[1:0];
      end
    endcase
    if (!agu_i_cmd_write) begin
      w_dec_strb = 4'b0000;
    end
  end

  // Selected slave ready/rdata via one-hot mask.
  always_comb begin
    w_rdy   = |(slv_lsu_ready & r_sel);
    w_rdata = '0;
    for (int i = 0; i < N_SLV; i++) begin
      if (r_sel[i]) begin
        w_rdata = w_rdata | slv_lsu_rdata[32*i +: 32];
      end
    end
  end

  always_comb begin
    w_sh  = w_rdata >> {r_addr[1:0], 3'b000};
    w_ext = w_sh;
    unique case (r_size)
      SZ_B: w_ext = r_usign ? {24'h0, w_sh[7:0]}
                            : {{24{w_sh[7]}}, w_sh[7:0]};
      SZ_H: w_ext = r_usign ? {16'h0, w_sh[15:0]}
                            : {{16{w_sh[15]}}, w_sh[15:0]};
      default: w_ext = w_sh;
    endcase
  end

  always_comb begin
    w_state = r_state;
    w_read  = r_read;
    w_write = r_write;
    w_usign = r_usign;
    w_size  = r_size;
    w_addr  = r_addr;
    w_wbus  = r_wbus;
    w_strb  = r_strb;
    w_sel   = r_sel;
    w_wbd   = r_wbd;
    w_err   = r_err;
    w_cause = r_cause;
`ifdef LSU_BUS_TIMEOUT_EN
    w_tmo   = r_tmo;
`endif
    unique case (r_state)
      IDLE: begin
        if (lsu_i_valid) begin
          w_read  = agu_i_cmd_read;
          w_write = agu_i_cmd_write;
          w_usign = agu_i_cmd_usign;
          w_size  = agu_i_cmd_size;
          w_addr  = agu_i_cmd_addr;
          w_wbus  = w_dec_wbus;
          w_strb  = w_dec_strb;
          w_sel   = w_dec_sel;
          w_wbd   = '0;
          w_err   = 1'b0;
          w_cause = C_NONE;
`ifdef LSU_BUS_TIMEOUT_EN
          w_tmo   = '0;
`endif
          if (w_mis) begin
            w_state = RESP;
            w_err   = 1'b1;
            w_cause = C_MIS;
          end else if (!w_hit) begin
            w_state = RESP;
            w_err   = 1'b1;
            w_cause = C_UNM;
          end else begin
            w_state = ACCESS;
          end
        end
      end
      ACCESS: begin
        if (w_rdy) begin
          w_wbd   = r_read ? w_ext : 32'h0;
          w_state = RESP;
        end
`ifdef LSU_BUS_TIMEOUT_EN
        else if (r_tmo == 8'(TMO_CYC - 1)) begin
          w_state = RESP;
          w_err   = 1'b1;
          w_cause = C_TMO;
        end else begin
          w_tmo = r_tmo + 8'd1;
        end
`endif
      end
      RESP: begin
        if (lsu_o_wbck_ready) begin
          w_state = IDLE;
        end
      end
      default: w_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_read  <= 1'b0;
      r_write <= 1'b0;
      r_usign <= 1'b0;
      r_size  <= 2'b00;
      r_addr  <= '0;
      r_wbus  <= '0;
      r_strb  <= '0;
      r_sel   <= '0;
      r_wbd   <= '0;
      r_err   <= 1'b0;
      r_cause <= C_NONE;
`ifdef LSU_BUS_TIMEOUT_EN
      r_tmo   <= '0;
`endif
    end else begin
      r_state <= w_state;
      r_read  <= w_read;
      r_write <= w_write;
      r_usign <= w_usign;
      r_size  <= w_size;
      r_addr  <= w_addr;
      r_wbus  <= w_wbus;
      r_strb  <= w_strb;
      r_sel   <= w_sel;
      r_wbd   <= w_wbd;
      r_err   <= w_err;
      r_cause <= w_cause;
`ifdef LSU_BUS_TIMEOUT_EN
      r_tmo   <= w_tmo;
`endif
    end
  end

  assign lsu_o_ready      = (r_state == IDLE);
  assign lsu_slv_valid    = (r_state == ACCESS) ? r_sel : '0;
  assign lsu_slv_wr       = r_write;
  assign lsu_slv_addr     = {r_addr[31:2], 2'b00};
  assign lsu_slv_wdata    = r_wbus;
  assign lsu_slv_wstrb    = r_strb;
  assign lsu_o_wbck_valid = (r_state == RESP);
  assign lsu_o_wbck_wdata = r_wbd;
  assign lsu_o_wbck_err   = r_err;
  assign lsu_o_wbck_cause = r_cause;

endmodule

// File: tb/tb_lsu_bus_ctrl.sv
// Directed bench for lsu_bus_ctrl: vector table plus reset,
// backpressure and (optionally) timeout sequences.

module tb_lsu_bus_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        lsu_i_valid;
  logic        lsu_o_ready;
  logic        agu_i_cmd_read;
  logic        agu_i_cmd_write;
  logic        agu_i_cmd_usign;
  logic [1:0]  agu_i_cmd_size;
  logic [31:0] agu_i_cmd_addr;
  logic [31:0] agu_i_cmd_wdata;
  logic [1:0]  lsu_slv_valid;
  logic        lsu_slv_wr;
  logic [31:0] lsu_slv_addr;
  logic [31:0] lsu_slv_wdata;
  logic [3:0]  lsu_slv_wstrb;
  logic [1:0]  slv_lsu_ready;
  logic [63:0] slv_lsu_rdata;
  logic        lsu_o_wbck_valid;
  logic        lsu_o_wbck_ready;
  logic [31:0] lsu_o_wbck_wdata;
  logic        lsu_o_wbck_err;
  logic [1:0]  lsu_o_wbck_cause;

  lsu_bus_ctrl #(.TMO_CYC(4)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .lsu_i_valid      (lsu_i_valid),
    .lsu_o_ready      (lsu_o_ready),
    .agu_i_cmd_read   (agu_i_cmd_read),
    .agu_i_cmd_write  (agu_i_cmd_write),
    .agu_i_cmd_usign  (agu_i_cmd_usign),
    .agu_i_cmd_size   (agu_i_cmd_size),
    .agu_i_cmd_addr   (agu_i_cmd_addr),
    .agu_i_cmd_wdata  (agu_i_cmd_wdata),
    .lsu_slv_valid    (lsu_slv_valid),
    .lsu_slv_wr       (lsu_slv_wr),
    .lsu_slv_addr     (lsu_slv_addr),
    .lsu_slv_wdata    (lsu_slv_wdata),
    .lsu_slv_wstrb    (lsu_slv_wstrb),
    .slv_lsu_ready    (slv_lsu_ready),
    .slv_lsu_rdata    (slv_lsu_rdata),
    .lsu_o_wbck_valid (lsu_o_wbck_valid),
    .lsu_o_wbck_ready (lsu_o_wbck_ready),
    .lsu_o_wbck_wdata (lsu_o_wbck_wdata),
    .lsu_o_wbck_err   (lsu_o_wbck_err),
    .lsu_o_wbck_cause (lsu_o_wbck_cause)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic        wr;
    logic        us;
    logic [1:0]  sz;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          dly;
    int          hold;
    logic [1:0]  sv;
    logic [3:0]  strb;
    logic [31:0] swd;
    logic [31:0] wb;
    logic        err;
    logic [1:0]  cause;
  } vec_t;

  localparam int NV = 14;
  vec_t tbl [NV];

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic drive_cmd(input vec_t v);
    agu_i_cmd_read  = v.rd;
    agu_i_cmd_write = v.wr;
    agu_i_cmd_usign = v.us;
    agu_i_cmd_size  = v.sz;
    agu_i_cmd_addr  = v.addr;
    agu_i_cmd_wdata = v.wdata;
    lsu_i_valid     = 1'b1;
  endtask

  // Disturb the AGU inputs right after accept.
  task automatic scramble;
    lsu_i_valid     = 1'b0;
    agu_i_cmd_read  = ~agu_i_cmd_read;
    agu_i_cmd_write = ~agu_i_cmd_write;
    agu_i_cmd_usign = ~agu_i_cmd_usign;
    agu_i_cmd_size  = 2'b11;
    agu_i_cmd_addr  = 32'h2000_0003;
    agu_i_cmd_wdata = ~agu_i_cmd_wdata;
  endtask

  task automatic hold_resp(input int n, input logic [31:0] wb,
                           input logic e, input logic [1:0] c);
    for (int h = 0; h < n; h++) begin
      @(posedge clk);
      @(negedge clk);
      chk("hold_wvalid", lsu_o_wbck_valid, 1'b1);
      chk("hold_wdata", lsu_o_wbck_wdata, wb);
      chk("hold_err", lsu_o_wbck_err, e);
      chk("hold_cause", lsu_o_wbck_cause, c);
      chk("hold_oready", lsu_o_ready, 1'b0);
    end
    lsu_o_wbck_ready = 1'b1;
    @(posedge clk);
    #1 lsu_o_wbck_ready = 1'b0;
  endtask

  task automatic run_vec(input int k, input vec_t v);
    @(negedge clk);
    chk($sformatf("v%0d_accept_rdy", k), lsu_o_ready, 1'b1);
    drive_cmd(v);
    @(posedge clk);
    #1 scramble();
    if (v.err) begin
      @(negedge clk);
      chk($sformatf("v%0d_err_sv", k), lsu_slv_valid, 2'b00);
      chk($sformatf("v%0d_err_wvalid", k), lsu_o_wbck_valid, 1'b1);
    end else begin
      for (int c = 0; c <= v.dly; c++) begin
        @(negedge clk);
        chk($sformatf("v%0d_sv_c%0d", k, c), lsu_slv_valid, v.sv);
        if (c == 0) begin
          chk($sformatf("v%0d_wvalid_early", k), lsu_o_wbck_valid, 1'b0);
          chk($sformatf("v%0d_wr", k), lsu_slv_wr, v.wr);
          chk($sformatf("v%0d_addr", k), lsu_slv_addr,
              {v.addr[31:2], 2'b00});
          chk($sformatf("v%0d_strb", k), lsu_slv_wstrb, v.strb);
          chk($sformatf("v%0d_swd", k), lsu_slv_wdata, v.swd);
        end
        if (c == v.dly) begin
          slv_lsu_ready = v.sv;
          slv_lsu_rdata[31:0]  = v.sv[0] ? v.rdata : 32'hDEAD_BEEF;
          slv_lsu_rdata[63:32] = v.sv[1] ? v.rdata : 32'hDEAD_BEEF;
        end
      end
      @(posedge clk);
      #1;
      slv_lsu_ready = 2'b00;
      slv_lsu_rdata = {2{32'h5A5A_5A5A}};
      @(negedge clk);
      chk($sformatf("v%0d_sv_drop", k), lsu_slv_valid, 2'b00);
      chk($sformatf("v%0d_wvalid", k), lsu_o_wbck_valid, 1'b1);
    end
    chk($sformatf("v%0d_wdata", k), lsu_o_wbck_wdata, v.wb);
    chk($sformatf("v%0d_err", k), lsu_o_wbck_err, v.err);
    chk($sformatf("v%0d_cause", k), lsu_o_wbck_cause, v.cause);
    hold_resp(v.hold, v.wb, v.err, v.cause);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    vec_t t;
    //        rd wr us sz     addr          wdata         rdata         dly hold sv     strb    swd           wb            err cause
    tbl[0]  = '{1, 0, 0, 2'b10, 32'h0000_0040, 32'h0,        32'h8765_4321, 0, 0, 2'b01, 4'h0, 32'h0,        32'h8765_4321, 0, 2'b00};
    tbl[1]  = '{1, 0, 0, 2'b00, 32'h0000_0043, 32'h0,        32'h80FF_FFFF, 0, 0, 2'b01, 4'h0, 32'h0,        32'hFFFF_FF80, 0, 2'b00};
    tbl[2]  = '{1, 0, 1, 2'b00, 32'h0000_0043, 32'h0,        32'h80FF_FFFF, 0, 0, 2'b01, 4'h0, 32'h0,        32'h0000_0080, 0, 2'b00};
    tbl[3]  = '{0, 1, 0, 2'b01, 32'h1000_0006, 32'h0000_ABCD, 32'h1111_2222, 1, 0, 2'b10, 4'hC, 32'hABCD_ABCD, 32'h0,        0, 2'b00};
    tbl[4]  = '{1, 0, 0, 2'b10, 32'h0000_0002, 32'h0,        32'h0,        0, 0, 2'b00, 4'h0, 32'h0,        32'h0,        1, 2'b01};
    tbl[5]  = '{1, 0, 0, 2'b10, 32'h2000_0000, 32'h0,        32'h0,        0, 0, 2'b00, 4'h0, 32'h0,        32'h0,        1, 2'b10};
    tbl[6]  = '{1, 0, 0, 2'b01, 32'h0000_0102, 32'h0,        32'h8001_1234, 2, 0, 2'b01, 4'h0, 32'h0,        32'hFFFF_8001, 0, 2'b00};
    tbl[7]  = '{1, 0, 1, 2'b01, 32'h1000_0010, 32'h0,        32'h1234_F00D, 0, 3, 2'b10, 4'h0, 32'h0,        32'h0000_F00D, 0, 2'b00};
    tbl[8]  = '{0, 1, 0, 2'b00, 32'h0000_0005, 32'h1234_56A5, 32'h0,        0, 0, 2'b01, 4'h2, 32'hA5A5_A5A5, 32'h0,        0, 2'b00};
    tbl[9]  = '{0, 1, 0, 2'b10, 32'h1000_001C, 32'hCAFE_F00D, 32'h0,        1, 0, 2'b10, 4'hF, 32'hCAFE_F00D, 32'h0,        0, 2'b00};
    tbl[10] = '{1, 0, 0, 2'b01, 32'h1000_0001, 32'h0,        32'h0,        0, 0, 2'b00, 4'h0, 32'h0,        32'h0,        1, 2'b01};
    tbl[11] = '{1, 0, 0, 2'b10, 32'h3000_0001, 32'h0,        32'h0,        0, 2, 2'b00, 4'h0, 32'h0,        32'h0,        1, 2'b01};
    tbl[12] = '{1, 0, 0, 2'b00, 32'h0000_0042, 32'h0,        32'h7F12_3456, 0, 0, 2'b01, 4'h0, 32'h0,        32'h0000_0012, 0, 2'b00};
    tbl[13] = '{0, 1, 0, 2'b00, 32'h2000_0003, 32'h0000_0077, 32'h0,        0, 0, 2'b00, 4'h0, 32'h0,        32'h0,        1, 2'b10};

    rst_n            = 1'b0;
    lsu_i_valid      = 1'b0;
    agu_i_cmd_read   = 1'b0;
    agu_i_cmd_write  = 1'b0;
    agu_i_cmd_usign  = 1'b0;
    agu_i_cmd_size   = 2'b00;
    agu_i_cmd_addr   = '0;
    agu_i_cmd_wdata  = '0;
    slv_lsu_ready    = 2'b00;
    slv_lsu_rdata    = '0;
    lsu_o_wbck_ready = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst_oready", lsu_o_ready, 1'b1);
    chk("rst_sv", lsu_slv_valid, 2'b00);
    chk("rst_wvalid", lsu_o_wbck_valid, 1'b0);
    chk("rst_err", lsu_o_wbck_err, 1'b0);
    chk("rst_cause", lsu_o_wbck_cause, 2'b00);
    chk("rst_wdata", lsu_o_wbck_wdata, 32'h0);
    chk("rst_wstrb", lsu_slv_wstrb, 4'h0);
    rst_n = 1'b1;

    for (int k = 0; k < NV; k++) begin
      run_vec(k, tbl[k]);
    end

    // Reset pulse while the slave is being held off.
    @(negedge clk);
    drive_cmd(tbl[0]);
    @(posedge clk);
    #1 scramble();
    @(negedge clk);
    chk("mid_sv_before", lsu_slv_valid, 2'b01);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_sv_async", lsu_slv_valid, 2'b00);
    chk("mid_oready", lsu_o_ready, 1'b1);
    chk("mid_wvalid", lsu_o_wbck_valid, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    run_vec(100, tbl[0]);

`ifdef LSU_BUS_TIMEOUT_EN
    // Slave never answers: valid must stay up for exactly TMO_CYC cycles.
    t = tbl[0];
    @(negedge clk);
    drive_cmd(t);
    @(posedge clk);
    #1 scramble();
    n = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (lsu_slv_valid == 2'b01) n++;
      else break;
    end
    chk("tmo_cycles", n, 4);
    chk("tmo_wvalid", lsu_o_wbck_valid, 1'b1);
    chk("tmo_err", lsu_o_wbck_err, 1'b1);
    chk("tmo_cause", lsu_o_wbck_cause, 2'b11);
    hold_resp(3, 32'h0, 1'b1, 2'b11);
    run_vec(200, tbl[0]);
`else
    t = tbl[0];
    n = 0;
`endif

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
